xgs_grab_sched: RTL and testbench

Grab scheduler for the XGS acquisition path: accepts host grab commands into a two-slot queue (current + pending), waits for a software or hardware trigger, applies trigger delay, times the sensor exposure window, then hands off to the readout datapath and waits for its completion. It sits between the host register file and the XGS sensor controller/readout chain and is the only block that sequences a frame acquisition.

---
 rtl/xgs_grab_sched.sv | 198 +++++++++++++++++++
 tb/tb_xgs_grab_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgs_grab_sched.sv
// xgs_grab_sched: grab sequencer for the XGS acquisition path.
// Holds a current grab plus one pending grab, waits for a software or hardware
// trigger, runs the trigger delay and exposure window, then kicks the readout
// datapath and waits for it to finish before the next frame may start.
module xgs_grab_sched #(
    parameter int EXP_W = 24,
    parameter int DLY_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk_i,
    input  logic             sys_reset_i,
    input  logic             grab_cmd_i,
    input  logic             grab_abort_i,
    input  logic             trig_mode_i,
    input  logic [EXP_W-1:0] exp_time_i,
    input  logic [DLY_W-1:0] trig_delay_i,
    input  logic             hw_trig_i,
    input  logic             readout_done_i,
    output logic             exp_active_o,
    output logic             readout_start_o,
    output logic             grab_active_o,
    output logic             grab_pending_o,
    output logic             idle_o,
    output logic             cmd_rejected_o,
    output logic             trig_missed_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        DELAY,
        EXPOSE,
        READOUT
    } state_e;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             mode_q, mode_d;
    logic [EXP_W-1:0] exp_snap_q, exp_snap_d;
    logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
    logic [DLY_W-1:0] dly_snap_q, dly_snap_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [CNT_W-1:0] frame_q, frame_d;

    logic exp_active_q, exp_active_d;
    logic readout_start_q, readout_start_d;
    logic grab_active_q, grab_active_d;
    logic idle_q, idle_d;
    logic cmd_rejected_q, cmd_rejected_d;
    logic trig_missed_q, trig_missed_d;

    logic cmd_ok;

    // An abort in the same cycle always kills the command.
    assign cmd_ok = grab_cmd_i & ~grab_abort_i;

    // State, snapshot, counter and registered-output flops.
    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            state_q         <= IDLE;
            pending_q       <= 1'b0;
            mode_q          <= 1'b0;
            exp_snap_q      <= '0;
            exp_cnt_q       <= '0;
            dly_snap_q      <= '0;
            dly_cnt_q       <= '0;
            frame_q         <= '0;
            exp_active_q    <= 1'b0;
            readout_start_q <= 1'b0;
            grab_active_q   <= 1'b0;
            idle_q          <= 1'b1;
            cmd_rejected_q  <= 1'b0;
            trig_missed_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            mode_q          <= mode_d;
            exp_snap_q      <= exp_snap_d;
            exp_cnt_q       <= exp_cnt_d;
            dly_snap_q      <= dly_snap_d;
            dly_cnt_q       <= dly_cnt_d;
            frame_q         <= frame_d;
            exp_active_q    <= exp_active_d;
            readout_start_q <= readout_start_d;
            grab_active_q   <= grab_active_d;
            idle_q          <= idle_d;
            cmd_rejected_q  <= cmd_rejected_d;
            trig_missed_q   <= trig_missed_d;
        end
    end

    // Next-state logic: queueing, trigger acceptance, delay/exposure timing, abort.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        mode_d     = mode_q;
        exp_snap_d = exp_snap_q;
        dly_snap_d = dly_snap_q;
        exp_cnt_d  = exp_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        frame_d    = frame_q;

        if (cmd_ok && (state_q != IDLE) && !pending_q) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_ok || pending_q) begin
                    state_d   = WAIT_TRIG;
                    pending_d = pending_q & cmd_ok;
                end
            end
            WAIT_TRIG: begin
                if (grab_abort_i) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else if (!mode_q || hw_trig_i) begin
                    if (dly_snap_q != '0) begin
                        state_d   = DELAY;
                        dly_cnt_d = dly_snap_q;
                    end else begin
                        state_d = EXPOSE;
                    end
                end
            end
            DELAY: begin
                if (grab_abort_i) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else if (dly_cnt_q == DLY_W'(1)) begin
                    state_d = EXPOSE;
                end else begin
                    dly_cnt_d = dly_cnt_q - DLY_W'(1);
                end
            end
            EXPOSE: begin
                if (grab_abort_i) begin
                    pending_d = 1'b0;
                end
                if (exp_cnt_q == EXP_W'(1)) begin
                    state_d = READOUT;
                end else begin
                    exp_cnt_d = exp_cnt_q - EXP_W'(1);
                end
            end
            READOUT: begin
                if (grab_abort_i) begin
                    pending_d = 1'b0;
                end
                if (readout_done_i) begin
                    frame_d = frame_q + CNT_W'(1);
                    if (pending_q && !grab_abort_i) begin
                        state_d   = WAIT_TRIG;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == WAIT_TRIG) && (state_q != WAIT_TRIG)) begin
            mode_d     = trig_mode_i;
            exp_snap_d = exp_time_i;
            dly_snap_d = trig_delay_i;
        end

        if ((state_d == EXPOSE) && (state_q != EXPOSE)) begin
            exp_cnt_d = (exp_snap_q == '0) ? EXP_W'(1) : exp_snap_q;
        end
    end

    // Output logic: next values of the registered status and pulse outputs.
    always_comb begin
        exp_active_d    = (state_d == EXPOSE);
        readout_start_d = (state_d == READOUT) && (state_q == EXPOSE);
        grab_active_d   = (state_d != IDLE);
        idle_d          = (state_d == IDLE);
        cmd_rejected_d  = grab_cmd_i && (grab_abort_i || ((state_q != IDLE) && pending_q));
        trig_missed_d   = hw_trig_i && mode_q &&
                          ((state_q == DELAY) || (state_q == EXPOSE) || (state_q == READOUT));
    end

    assign exp_active_o    = exp_active_q;
    assign readout_start_o = readout_start_q;
    assign grab_active_o   = grab_active_q;
    assign grab_pending_o  = pending_q;
    assign idle_o          = idle_q;
    assign cmd_rejected_o  = cmd_rejected_q;
    assign trig_missed_o   = trig_missed_q;
    assign frame_cnt_o     = frame_q;

endmodule

// File: tb/tb_xgs_grab_sched.sv
// tb_xgs_grab_sched: directed bench for the grab scheduler.
// A timeline model predicts every output each cycle from trigger time, delay
// and exposure length; literal spot checks pin the model at key cycles.
module tb_xgs_grab_sched;

    localparam int EXP_W = 24;
    localparam int DLY_W = 16;
    localparam int CNT_W = 4;

    logic             sysClk;
    logic             sysReset;
    logic             grabCmd;
    logic             grabAbort;
    logic             trigMode;
    logic [EXP_W-1:0] expTime;
    logic [DLY_W-1:0] trigDelay;
    logic             hwTrig;
    logic             readoutDone;
    logic             expActive;
    logic             readoutStart;
    logic             grabActive;
    logic             grabPending;
    logic             idle;
    logic             cmdRejected;
    logic             trigMissed;
    logic [CNT_W-1:0] frameCnt;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    // timeline model state
    bit mBusy;
    bit mPend;
    bit mMode;
    int mTrig;
    int mD;
    int mE;
    int mFrame;
    bit modelValid = 0;

    // model predictions for the current cycle
    bit eExp, eRs, eAct, ePend, eIdle, eRej, eMiss;
    int eFrame;

    xgs_grab_sched #(
        .EXP_W(EXP_W),
        .DLY_W(DLY_W),
        .CNT_W(CNT_W)
    ) dut (
        .sys_clk_i      (sysClk),
        .sys_reset_i    (sysReset),
        .grab_cmd_i     (grabCmd),
        .grab_abort_i   (grabAbort),
        .trig_mode_i    (trigMode),
        .exp_time_i     (expTime),
        .trig_delay_i   (trigDelay),
        .hw_trig_i      (hwTrig),
        .readout_done_i (readoutDone),
        .exp_active_o   (expActive),
        .readout_start_o(readoutStart),
        .grab_active_o  (grabActive),
        .grab_pending_o (grabPending),
        .idle_o         (idle),
        .cmd_rejected_o (cmdRejected),
        .trig_missed_o  (trigMissed),
        .frame_cnt_o    (frameCnt)
    );

    // Free-running clock, period 10.
    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    // Hard time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, actual, expected);
        end
    endtask

    // Phase of the current grab at cycle m: 0 idle, 1 waiting, 2 delay, 3 expose, 4 readout.
    function automatic int phaseAt(input int m);
        if (!mBusy)                   return 0;
        if (mTrig < 0 || m <= mTrig)  return 1;
        if (m <= mTrig + mD)          return 2;
        if (m <= mTrig + mD + mE)     return 3;
        return 4;
    endfunction

    function automatic void startGrab();
        mBusy = 1'b1;
        mTrig = -1;
        mMode = trigMode;
        mD    = int'(trigDelay);
        mE    = (expTime == '0) ? 1 : int'(expTime);
    endfunction

    // Model: at each edge, apply this cycle's inputs and predict the next cycle.
    always @(posedge sysClk) begin
        int n;
        int ph;
        bit oldPend;
        bit cmdOk;
        n = cyc;
        if (sysReset) begin
            mBusy  = 0;
            mPend  = 0;
            mTrig  = -1;
            mFrame = 0;
            eRej   = 0;
            eMiss  = 0;
            modelValid = 1;
        end else begin
            ph      = phaseAt(n);
            oldPend = mPend;
            cmdOk   = grabCmd && !grabAbort;
            eRej    = grabCmd && (grabAbort || (ph != 0 && oldPend));
            eMiss   = hwTrig && mMode && (ph >= 2);
            if (cmdOk && ph != 0 && !oldPend) mPend = 1;
            case (ph)
                0: if (cmdOk || oldPend) begin
                       startGrab();
                       mPend = oldPend && cmdOk;
                   end
                1: if (grabAbort) begin
                       mBusy = 0;
                       mPend = 0;
                   end else if (!mMode || hwTrig) begin
                       mTrig = n;
                   end
                2: if (grabAbort) begin
                       mBusy = 0;
                       mPend = 0;
                   end
                3: if (grabAbort) mPend = 0;
                default: begin
                    if (grabAbort) mPend = 0;
                    if (readoutDone) begin
                        mFrame = (mFrame + 1) % 16;
                        if (oldPend && !grabAbort) begin
                            startGrab();
                            mPend = 0;
                        end else begin
                            mBusy = 0;
                        end
                    end
                end
            endcase
        end
        ph     = phaseAt(n + 1);
        eExp   = (ph == 3);
        eRs    = (ph == 4) && (n + 1 == mTrig + mD + mE + 1);
        eAct   = mBusy;
        eIdle  = !mBusy;
        ePend  = mPend;
        eFrame = mFrame;
        cyc    = n + 1;
    end

    // Compare every output against the model on every cycle.
    always @(negedge sysClk) begin
        if (modelValid) begin
            checkOutput("exp_active",    int'(expActive),    int'(eExp));
            checkOutput("readout_start", int'(readoutStart), int'(eRs));
            checkOutput("grab_active",   int'(grabActive),   int'(eAct));
            checkOutput("grab_pending",  int'(grabPending),  int'(ePend));
            checkOutput("idle",          int'(idle),         int'(eIdle));
            checkOutput("cmd_rejected",  int'(cmdRejected),  int'(eRej));
            checkOutput("trig_missed",   int'(trigMissed),   int'(eMiss));
            checkOutput("frame_cnt",     int'(frameCnt),     eFrame);
        end
    end

    // Drive one cycle of pulses, then return at the next negedge with them cleared.
    task automatic applyStimulus(input bit cmd, input bit abort, input bit hw, input bit done);
        grabCmd     = cmd;
        grabAbort   = abort;
        hwTrig      = hw;
        readoutDone = done;
        @(negedge sysClk);
        grabCmd     = 1'b0;
        grabAbort   = 1'b0;
        hwTrig      = 1'b0;
        readoutDone = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    initial begin
        sysReset    = 1'b1;
        grabCmd     = 1'b0;
        grabAbort   = 1'b0;
        trigMode    = 1'b0;
        expTime     = EXP_W'(100);
        trigDelay   = '0;
        hwTrig      = 1'b0;
        readoutDone = 1'b0;
        repeat (2) @(negedge sysClk);
        checkOutput("lit reset idle",        int'(idle),       1);
        checkOutput("lit reset grab_active", int'(grabActive), 0);
        checkOutput("lit reset frame_cnt",   int'(frameCnt),   0);
        sysReset = 1'b0;
        idleCycles(3);

        // immediate trigger, delay 0, exposure 100
        applyStimulus(1, 0, 0, 0);
        checkOutput("lit t1 grab_active", int'(grabActive), 1);
        checkOutput("lit t1 exp_pre",     int'(expActive),  0);
        idleCycles(1);
        checkOutput("lit t1 exp_first",   int'(expActive),  1);
        idleCycles(99);
        checkOutput("lit t1 exp_last",    int'(expActive),  1);
        idleCycles(1);
        checkOutput("lit t1 exp_after",   int'(expActive),  0);
        checkOutput("lit t1 rd_start",    int'(readoutStart), 1);
        idleCycles(38);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit t1 frame",       int'(frameCnt), 1);
        checkOutput("lit t1 idle",        int'(idle),     1);
        idleCycles(2);

        // hardware trigger, delay 5, exposure 0; settings changed mid-grab
        trigMode  = 1'b1;
        trigDelay = DLY_W'(5);
        expTime   = '0;
        applyStimulus(1, 0, 0, 0);
        trigMode  = 1'b0;
        trigDelay = '0;
        expTime   = EXP_W'(7);
        idleCycles(3);
        checkOutput("lit t2 still_waiting", int'(expActive) + 2 * int'(grabActive), 2);
        applyStimulus(0, 0, 1, 0);
        idleCycles(4);
        checkOutput("lit t2 exp_in_delay", int'(expActive), 0);
        idleCycles(1);
        checkOutput("lit t2 exp_single", int'(expActive), 1);
        idleCycles(1);
        checkOutput("lit t2 exp_off",    int'(expActive),    0);
        checkOutput("lit t2 rd_start",   int'(readoutStart), 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lit t2 trig_missed", int'(trigMissed), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit t2 frame", int'(frameCnt), 2);
        idleCycles(2);

        // queue full: commands at q, q+2, q+4
        trigMode = 1'b1;
        expTime  = EXP_W'(3);
        applyStimulus(1, 0, 0, 0);
        idleCycles(1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lit t3 pending", int'(grabPending), 1);
        idleCycles(1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lit t3 rejected", int'(cmdRejected), 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(3);
        checkOutput("lit t3 rd_start", int'(readoutStart), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit t3 frame3",  int'(frameCnt),    3);
        checkOutput("lit t3 next",    int'(grabActive),  1);
        checkOutput("lit t3 pend_clr", int'(grabPending), 0);
        applyStimulus(0, 0, 1, 0);
        idleCycles(3);
        // readout_done with a new command and an empty pending slot
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit t3 idle_gap", int'(idle),        1);
        checkOutput("lit t3 queued",   int'(grabPending), 1);
        checkOutput("lit t3 frame4",   int'(frameCnt),    4);
        idleCycles(1);
        checkOutput("lit t3 restart",  int'(grabActive),  1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("lit t3 abort_wait", int'(idle), 1);
        idleCycles(2);

        // abort during a long delay with a pending grab
        trigDelay = DLY_W'(1000);
        expTime   = EXP_W'(5);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        idleCycles(9);
        applyStimulus(0, 1, 0, 0);
        checkOutput("lit t4 idle",    int'(idle),        1);
        checkOutput("lit t4 pending", int'(grabPending), 0);
        checkOutput("lit t4 frame",   int'(frameCnt),    4);
        idleCycles(3);

        // abort (with a colliding command) during exposure
        trigMode  = 1'b0;
        trigDelay = '0;
        expTime   = EXP_W'(20);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lit t5 pending", int'(grabPending), 1);
        idleCycles(3);
        applyStimulus(1, 1, 0, 0);
        checkOutput("lit t5 pend_clr", int'(grabPending), 0);
        checkOutput("lit t5 rejected", int'(cmdRejected), 1);
        idleCycles(15);
        checkOutput("lit t5 exp_last", int'(expActive), 1);
        idleCycles(1);
        checkOutput("lit t5 rd_start", int'(readoutStart), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit t5 frame", int'(frameCnt), 5);
        checkOutput("lit t5 idle",  int'(idle),     1);
        idleCycles(1);

        // frame counter wrap with short grabs
        expTime = EXP_W'(1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, 0, (i == 0), 0);
            idleCycles(2);
            applyStimulus(0, 0, 0, 1);
            if (i == 9) checkOutput("lit t6 frame15", int'(frameCnt), 15);
        end
        checkOutput("lit t6 wrapped", int'(frameCnt), 0);
        idleCycles(2);

        // reset in the middle of an exposure
        expTime = EXP_W'(50);
        applyStimulus(1, 0, 0, 0);
        idleCycles(9);
        checkOutput("lit t7 exposing", int'(expActive), 1);
        sysReset = 1'b1;
        @(negedge sysClk);
        sysReset = 1'b0;
        checkOutput("lit t7 exp_off", int'(expActive), 0);
        checkOutput("lit t7 idle",    int'(idle),      1);
        idleCycles(60);
        checkOutput("lit t7 frame",   int'(frameCnt),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
